// File: rtl/mmr_gpio_bank_handshake.sv
// Memory-mapped GPIO bank: OUT/IN/SET/CLR/TGL/IE/IP registers per channel behind a req/ack/err handshake.
// Inputs are optionally synchronised and feed per-bit rising-edge interrupt pending bits.
module mmr_gpio_bank_handshake #(
    parameter int                GPIO_N    = 8,
    parameter int                GPIO_W    = 32,
    parameter logic [GPIO_W-1:0] OUT_RESET = '0,
    parameter bit                SYNC_EN   = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       req,
    input  logic                       wr,
    input  logic [2+$clog2(GPIO_N):0]  addr,
    input  logic [GPIO_W/8-1:0]        be,
    input  logic [GPIO_W-1:0]          wdata,
    output logic                       ack,
    output logic                       err,
    output logic [GPIO_W-1:0]          rdata,
    output logic [GPIO_N*GPIO_W-1:0]   gpio_o,
    input  logic [GPIO_N*GPIO_W-1:0]   gpio_i,
    output logic [GPIO_N-1:0]          gpio_o_update,
    output logic [GPIO_N-1:0]          gpio_i_update,
    output logic                       irq
);

    localparam int CLOG = $clog2(GPIO_N);
    localparam int AW   = 3 + CLOG;
    localparam int BW   = GPIO_W / 8;
    localparam int CHW  = (CLOG > 0) ? CLOG : 1;
    localparam int NW   = GPIO_N * GPIO_W;

    typedef enum logic [2:0] {
        REG_OUT  = 3'd0,
        REG_IN   = 3'd1,
        REG_SET  = 3'd2,
        REG_CLR  = 3'd3,
        REG_TGL  = 3'd4,
        REG_IE   = 3'd5,
        REG_IP   = 3'd6,
        REG_RSVD = 3'd7
    } reg_e;

    reg_e             rsel;
    logic [CHW-1:0]   ch;
    logic             accept;
    logic             be_any;
    logic             acc_err;
    logic [GPIO_W-1:0] bemask;
    logic [GPIO_W-1:0] wmask;
    logic [GPIO_W-1:0] rd_val;
    logic [NW-1:0]    s;
    logic [NW-1:0]    prev_q;
    logic [NW-1:0]    rise;
    logic [GPIO_N-1:0] irq_ch;

    logic [GPIO_W-1:0] out_q [GPIO_N];
    logic [GPIO_W-1:0] ie_q  [GPIO_N];
    logic [GPIO_W-1:0] ip_q  [GPIO_N];
    logic [GPIO_W-1:0] w1c   [GPIO_N];

    assign rsel = reg_e'(addr[AW-1 -: 3]);

    generate
        if (CLOG > 0) begin : g_ch
            assign ch = addr[CHW-1:0];
        end else begin : g_ch_single
            assign ch = '0;
        end
    endgenerate

    // Input path: two-flop synchroniser, or direct when gpio_i is already in the clk domain.
    generate
        if (SYNC_EN) begin : g_sync
            logic [NW-1:0] s1_q;
            logic [NW-1:0] s2_q;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    s1_q <= '0;
                    s2_q <= '0;
                end else begin
                    s1_q <= gpio_i;
                    s2_q <= s1_q;
                end
            end
            assign s = s2_q;
        end else begin : g_nosync
            assign s = gpio_i;
        end
    endgenerate

    always_comb begin
        bemask = '0;
        for (int b = 0; b < BW; b++) begin
            bemask[b*8 +: 8] = {8{be[b]}};
        end
    end

    // Valid/ready: a request is taken on an edge with req && !ack; the ack cycle never re-accepts.
    assign accept  = req && !ack;
    assign be_any  = |be;
    assign wmask   = wdata & bemask;
    assign rise    = s & ~prev_q;
    assign acc_err = (rsel == REG_RSVD) || ((rsel == REG_IN) && wr);

    always_comb begin
        rd_val = '0;
        case (rsel)
            REG_OUT: rd_val = out_q[ch];
            REG_IN:  rd_val = s[int'(ch)*GPIO_W +: GPIO_W];
            REG_IE:  rd_val = ie_q[ch];
            REG_IP:  rd_val = ip_q[ch];
            default: rd_val = '0;
        endcase
    end

    always_comb begin
        irq_ch = '0;
        gpio_o = '0;
        for (int c = 0; c < GPIO_N; c++) begin
            w1c[c] = '0;
            if (accept && wr && (rsel == REG_IP) && (int'(ch) == c)) begin
                w1c[c] = wmask;
            end
            irq_ch[c] = |(ip_q[c] & ie_q[c]);
            gpio_o[c*GPIO_W +: GPIO_W] = out_q[c];
        end
    end

    assign irq = |irq_ch;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack           <= 1'b0;
            err           <= 1'b0;
            rdata         <= '0;
            gpio_o_update <= '0;
            gpio_i_update <= '0;
            prev_q        <= '0;
            for (int c = 0; c < GPIO_N; c++) begin
                out_q[c] <= OUT_RESET;
                ie_q[c]  <= '0;
                ip_q[c]  <= '0;
            end
        end else begin
            ack           <= accept;
            err           <= accept && acc_err;
            rdata         <= (accept && !wr) ? rd_val : '0;
            gpio_o_update <= '0;
            gpio_i_update <= '0;
            prev_q        <= s;

            // A fresh edge beats a simultaneous write-1-to-clear of the same bit.
            for (int c = 0; c < GPIO_N; c++) begin
                ip_q[c] <= (ip_q[c] & ~w1c[c]) | (rise[c*GPIO_W +: GPIO_W] & ie_q[c]);
            end

            if (accept && wr && be_any) begin
                case (rsel)
                    REG_OUT: begin
                        out_q[ch]         <= (out_q[ch] & ~bemask) | wmask;
                        gpio_o_update[ch] <= 1'b1;
                    end
                    REG_SET: begin
                        out_q[ch]         <= out_q[ch] | wmask;
                        gpio_o_update[ch] <= 1'b1;
                    end
                    REG_CLR: begin
                        out_q[ch]         <= out_q[ch] & ~wmask;
                        gpio_o_update[ch] <= 1'b1;
                    end
                    REG_TGL: begin
                        out_q[ch]         <= out_q[ch] ^ wmask;
                        gpio_o_update[ch] <= 1'b1;
                    end
                    REG_IE: begin
                        ie_q[ch] <= (ie_q[ch] & ~bemask) | wmask;
                    end
                    default: begin
                    end
                endcase
            end

            if (accept && !wr && (rsel == REG_IN)) begin
                gpio_i_update[ch] <= 1'b1;
            end
        end
    end

endmodule
